// File: rtl/csr_regs_pkg.sv
// Shared definitions for the machine-mode CSR file and the trap unit:
// CSR addresses, Zicsr op encodings, reset/mask constants, trap bundle layout.
package csr_regs_pkg;

  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MISA     = 12'h301;
  localparam logic [11:0] CSR_MIE      = 12'h304;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MTVAL    = 12'h343;
  localparam logic [11:0] CSR_MIP      = 12'h344;
  localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET = 12'hB02;
  localparam logic [11:0] CSR_MHARTID  = 12'hF14;

  typedef enum logic [1:0] {
    CSR_OP_NONE = 2'b00,
    CSR_OP_RW   = 2'b01,
    CSR_OP_RS   = 2'b10,
    CSR_OP_RC   = 2'b11
  } csr_op_e;

  localparam logic [63:0] MSTATUS_RST = 64'h0000_000A_0000_1800;
  // Direct-mode mtvec and 4-byte aligned mepc: low two bits always read 0
  localparam logic [63:0] MTVEC_MASK  = ~64'h3;
  localparam logic [63:0] MEPC_MASK   = ~64'h3;

  // Trap write bundle, shared field layout with the trap unit
  typedef struct packed {
    logic [63:0] mepc;
    logic [63:0] mcause;
    logic [63:0] mstatus;
  } trap_wr_t;

  // Read-modify-write result for a Zicsr op
  function automatic logic [63:0] csr_apply(input csr_op_e op,
                                            input logic [63:0] old_val,
                                            input logic [63:0] src);
    logic [63:0] res;
    res = old_val;
    case (op)
      CSR_OP_RW: res = src;
      CSR_OP_RS: res = old_val | src;
      CSR_OP_RC: res = old_val & ~src;
      default:   res = old_val;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/csr_counter.sv
// 64-bit free-running counter with enable, parallel load and sync reset.
// Load has priority over increment; wraps naturally at 2^64.
module csr_counter (
  input  logic        clk,
  input  logic        rst,
  input  logic        en_i,
  input  logic        ld_i,
  input  logic [63:0] ld_data_i,
  output logic [63:0] cnt_o
);

  logic [63:0] cnt_d, cnt_q;

  // Next count: load replaces the increment
  always_comb begin
    cnt_d = cnt_q;
    if (ld_i)      cnt_d = ld_data_i;
    else if (en_i) cnt_d = cnt_q + 64'd1;
  end

  // Count register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/csr_regs.sv
// Machine-mode CSR register file for the RV64 core.
// Serves Zicsr read-modify-write accesses, accepts the trap unit's write
// bundle (trap beats Zicsr), and feeds mtvec/mepc/mstatus back.
// Define CSR_COUNTERS_EN to implement mcycle/minstret; otherwise their
// addresses decode as unimplemented and inst_retire_i is ignored.
module csr_regs
  import csr_regs_pkg::*;
#(
  parameter logic [63:0] HART_ID  = 64'd0,
  parameter logic [63:0] MISA_VAL = 64'h8000_0000_0000_1100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] csr_addr_i,
  input  logic [1:0]  csr_op_i,
  input  logic        csr_wen_i,
  input  logic [63:0] csr_src_i,
  output logic [63:0] csr_rdata_o,
  output logic        csr_illegal_o,
  input  logic        trap_wen_i,
  input  logic [63:0] trap_mepc_i,
  input  logic [63:0] trap_mcause_i,
  input  logic [63:0] trap_mstatus_i,
  input  logic        inst_retire_i,
  output logic [63:0] mtvec_o,
  output logic [63:0] mepc_o,
  output logic [63:0] mstatus_o
);

  logic [63:0] mstatus_d, mstatus_q;
  logic [63:0] mie_d, mie_q;
  logic [63:0] mtvec_d, mtvec_q;
  logic [63:0] mscratch_d, mscratch_q;
  logic [63:0] mepc_d, mepc_q;
  logic [63:0] mcause_d, mcause_q;
  logic [63:0] mtval_d, mtval_q;

  logic [63:0] rd_raw;
  logic        impl;
  logic        ro;
  logic        illegal;
  logic        csr_we;
  logic [63:0] wdata;
  csr_op_e     op;
  trap_wr_t    trap_wr;

  assign op      = csr_op_e'(csr_op_i);
  assign trap_wr = {trap_mepc_i, trap_mcause_i, trap_mstatus_i};

`ifdef CSR_COUNTERS_EN
  logic [63:0] mcycle, minstret;
`else
  logic unused_retire;
  assign unused_retire = inst_retire_i;
`endif

  // Address decode: old value, implemented and read-only flags
  always_comb begin
    rd_raw = '0;
    impl   = 1'b1;
    ro     = 1'b0;
    case (csr_addr_i)
      CSR_MSTATUS:  rd_raw = mstatus_q;
      CSR_MISA:     begin rd_raw = MISA_VAL; ro = 1'b1; end
      CSR_MIE:      rd_raw = mie_q;
      CSR_MTVEC:    rd_raw = mtvec_q;
      CSR_MSCRATCH: rd_raw = mscratch_q;
      CSR_MEPC:     rd_raw = mepc_q;
      CSR_MCAUSE:   rd_raw = mcause_q;
      CSR_MTVAL:    rd_raw = mtval_q;
      CSR_MIP:      begin rd_raw = '0; ro = 1'b1; end
      CSR_MHARTID:  begin rd_raw = HART_ID; ro = 1'b1; end
`ifdef CSR_COUNTERS_EN
      CSR_MCYCLE:   rd_raw = mcycle;
      CSR_MINSTRET: rd_raw = minstret;
`endif
      default:      impl = 1'b0;
    endcase
  end

  assign illegal       = !impl || (ro && csr_wen_i);
  assign csr_illegal_o = illegal;
  assign csr_rdata_o   = illegal ? 64'd0 : rd_raw;
  // A coincident trap write discards the Zicsr write whatever its target
  assign csr_we        = csr_wen_i && (op != CSR_OP_NONE) && !illegal && !trap_wen_i;
  assign wdata         = csr_apply(op, rd_raw, csr_src_i);

  // Next-state for the plain registers: trap bundle first, then Zicsr
  always_comb begin
    mstatus_d  = mstatus_q;
    mie_d      = mie_q;
    mtvec_d    = mtvec_q;
    mscratch_d = mscratch_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;
    mtval_d    = mtval_q;
    if (trap_wen_i) begin
      mepc_d    = trap_wr.mepc & MEPC_MASK;
      mcause_d  = trap_wr.mcause;
      mstatus_d = trap_wr.mstatus;
    end else if (csr_we) begin
      case (csr_addr_i)
        CSR_MSTATUS:  mstatus_d  = wdata;
        CSR_MIE:      mie_d      = wdata;
        CSR_MTVEC:    mtvec_d    = wdata & MTVEC_MASK;
        CSR_MSCRATCH: mscratch_d = wdata;
        CSR_MEPC:     mepc_d     = wdata & MEPC_MASK;
        CSR_MCAUSE:   mcause_d   = wdata;
        CSR_MTVAL:    mtval_d    = wdata;
        default:      ;
      endcase
    end
  end

  // Register state with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      mstatus_q  <= MSTATUS_RST;
      mie_q      <= '0;
      mtvec_q    <= '0;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mtval_q    <= '0;
    end else begin
      mstatus_q  <= mstatus_d;
      mie_q      <= mie_d;
      mtvec_q    <= mtvec_d;
      mscratch_q <= mscratch_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
      mtval_q    <= mtval_d;
    end
  end

`ifdef CSR_COUNTERS_EN
  csr_counter u_mcycle (
    .clk       (clk),
    .rst       (rst),
    .en_i      (1'b1),
    .ld_i      (csr_we && (csr_addr_i == CSR_MCYCLE)),
    .ld_data_i (wdata),
    .cnt_o     (mcycle)
  );

  csr_counter u_minstret (
    .clk       (clk),
    .rst       (rst),
    .en_i      (inst_retire_i),
    .ld_i      (csr_we && (csr_addr_i == CSR_MINSTRET)),
    .ld_data_i (wdata),
    .cnt_o     (minstret)
  );
`endif

  assign mtvec_o   = mtvec_q;
  assign mepc_o    = mepc_q;
  assign mstatus_o = mstatus_q;

endmodule

// File: tb/tb_csr_regs.sv
// Directed self-checking bench for csr_regs. Inputs change 1ns after the
// rising edge; outputs are checked 1ns later, well before the next edge.
module tb_csr_regs;

  localparam logic [63:0] TB_HART = 64'd3;
  localparam logic [63:0] TB_MISA = 64'h8000_0000_0000_1100;
  localparam logic [63:0] TB_MST  = 64'h0000_000A_0000_1800;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] csr_addr_i;
  logic [1:0]  csr_op_i;
  logic        csr_wen_i;
  logic [63:0] csr_src_i;
  logic [63:0] csr_rdata_o;
  logic        csr_illegal_o;
  logic        trap_wen_i;
  logic [63:0] trap_mepc_i;
  logic [63:0] trap_mcause_i;
  logic [63:0] trap_mstatus_i;
  logic        inst_retire_i;
  logic [63:0] mtvec_o, mepc_o, mstatus_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  csr_regs #(.HART_ID(TB_HART), .MISA_VAL(TB_MISA)) dut (
    .clk            (clk),
    .rst            (rst),
    .csr_addr_i     (csr_addr_i),
    .csr_op_i       (csr_op_i),
    .csr_wen_i      (csr_wen_i),
    .csr_src_i      (csr_src_i),
    .csr_rdata_o    (csr_rdata_o),
    .csr_illegal_o  (csr_illegal_o),
    .trap_wen_i     (trap_wen_i),
    .trap_mepc_i    (trap_mepc_i),
    .trap_mcause_i  (trap_mcause_i),
    .trap_mstatus_i (trap_mstatus_i),
    .inst_retire_i  (inst_retire_i),
    .mtvec_o        (mtvec_o),
    .mepc_o         (mepc_o),
    .mstatus_o      (mstatus_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    csr_addr_i     = 12'h000;
    csr_op_i       = 2'b00;
    csr_wen_i      = 1'b0;
    csr_src_i      = '0;
    trap_wen_i     = 1'b0;
    trap_mepc_i    = '0;
    trap_mcause_i  = '0;
    trap_mstatus_i = '0;
    inst_retire_i  = 1'b0;
  endtask

  task automatic rd(input logic [11:0] a);
    csr_addr_i = a;
    csr_op_i   = 2'b00;
    csr_wen_i  = 1'b0;
    #1;
  endtask

  task automatic wr(input logic [11:0] a, input logic [1:0] op, input logic [63:0] s);
    csr_addr_i = a;
    csr_op_i   = op;
    csr_wen_i  = 1'b1;
    csr_src_i  = s;
    #1;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if (mstatus_o !== TB_MST) begin
      errors++; $display("FAIL reset_mstatus got %h want %h", mstatus_o, TB_MST);
    end
    checks++;
    if (mtvec_o !== 64'd0 || mepc_o !== 64'd0) begin
      errors++; $display("FAIL reset_mtvec_mepc got %h/%h want 0/0", mtvec_o, mepc_o);
    end
    rst = 1'b0;
    rd(12'hF14);
    checks++;
    if (csr_rdata_o !== TB_HART || csr_illegal_o !== 1'b0) begin
      errors++; $display("FAIL mhartid got %h ill %b want %h ill 0", csr_rdata_o, csr_illegal_o, TB_HART);
    end
    rd(12'h301);
    checks++;
    if (csr_rdata_o !== TB_MISA) begin
      errors++; $display("FAIL misa got %h want %h", csr_rdata_o, TB_MISA);
    end
    tick();
  endtask

  task automatic test_rw_rs_rc();
    wr(12'h340, 2'b01, 64'hF0);
    checks++;
    if (csr_rdata_o !== 64'h0) begin
      errors++; $display("FAIL rw_old got %h want 0", csr_rdata_o);
    end
    tick();
    wr(12'h340, 2'b10, 64'h0F);
    checks++;
    if (csr_rdata_o !== 64'hF0) begin
      errors++; $display("FAIL rs_old got %h want f0", csr_rdata_o);
    end
    tick();
    wr(12'h340, 2'b11, 64'h3C);
    checks++;
    if (csr_rdata_o !== 64'hFF) begin
      errors++; $display("FAIL rc_old got %h want ff", csr_rdata_o);
    end
    tick();
    rd(12'h340);
    checks++;
    if (csr_rdata_o !== 64'hC3) begin
      errors++; $display("FAIL mscratch_final got %h want c3", csr_rdata_o);
    end
    // wen with op none must not write
    wr(12'h340, 2'b00, 64'h1234);
    tick();
    rd(12'h340);
    checks++;
    if (csr_rdata_o !== 64'hC3) begin
      errors++; $display("FAIL op_none_write got %h want c3", csr_rdata_o);
    end
  endtask

  task automatic test_masking();
    wr(12'h305, 2'b01, 64'h8000_0003);
    tick();
    idle();
    #1;
    checks++;
    if (mtvec_o !== 64'h8000_0000) begin
      errors++; $display("FAIL mtvec_mask got %h want 80000000", mtvec_o);
    end
    trap_wen_i     = 1'b1;
    trap_mepc_i    = 64'h8000_0106;
    trap_mcause_i  = 64'd2;
    trap_mstatus_i = 64'h80;
    tick();
    idle();
    #1;
    checks++;
    if (mepc_o !== 64'h8000_0104) begin
      errors++; $display("FAIL trap_mepc_mask got %h want 80000104", mepc_o);
    end
    checks++;
    if (mstatus_o !== 64'h80) begin
      errors++; $display("FAIL trap_mstatus got %h want 80", mstatus_o);
    end
    wr(12'h341, 2'b01, 64'h4000_0007);
    tick();
    idle();
    #1;
    checks++;
    if (mepc_o !== 64'h4000_0004) begin
      errors++; $display("FAIL csr_mepc_mask got %h want 40000004", mepc_o);
    end
  endtask

  task automatic test_trap_conflict();
    trap_wen_i     = 1'b1;
    trap_mepc_i    = 64'h200;
    trap_mcause_i  = 64'd11;
    trap_mstatus_i = 64'h1880;
    wr(12'h342, 2'b01, 64'd5);
    tick();
    idle();
    rd(12'h342);
    checks++;
    if (csr_rdata_o !== 64'd11) begin
      errors++; $display("FAIL trap_vs_csr_mcause got %0d want 11", csr_rdata_o);
    end
    // Conflicting Zicsr write to an unrelated CSR is dropped too
    trap_wen_i     = 1'b1;
    trap_mepc_i    = 64'h300;
    trap_mcause_i  = 64'd7;
    trap_mstatus_i = 64'h1880;
    wr(12'h340, 2'b01, 64'hDEAD);
    tick();
    idle();
    rd(12'h340);
    checks++;
    if (csr_rdata_o !== 64'hC3) begin
      errors++; $display("FAIL trap_vs_csr_other got %h want c3", csr_rdata_o);
    end
  endtask

  task automatic test_illegal();
    wr(12'h301, 2'b01, 64'd0);
    checks++;
    if (csr_illegal_o !== 1'b1 || csr_rdata_o !== 64'd0) begin
      errors++; $display("FAIL misa_write ill %b rdata %h want ill 1 rdata 0", csr_illegal_o, csr_rdata_o);
    end
    tick();
    idle();
    rd(12'h301);
    checks++;
    if (csr_rdata_o !== TB_MISA || csr_illegal_o !== 1'b0) begin
      errors++; $display("FAIL misa_kept got %h ill %b want %h ill 0", csr_rdata_o, csr_illegal_o, TB_MISA);
    end
    rd(12'h7C0);
    checks++;
    if (csr_illegal_o !== 1'b1 || csr_rdata_o !== 64'd0) begin
      errors++; $display("FAIL unimpl_read ill %b rdata %h want ill 1 rdata 0", csr_illegal_o, csr_rdata_o);
    end
    rd(12'h344);
    checks++;
    if (csr_illegal_o !== 1'b0 || csr_rdata_o !== 64'd0) begin
      errors++; $display("FAIL mip_read ill %b rdata %h want ill 0 rdata 0", csr_illegal_o, csr_rdata_o);
    end
  endtask

  task automatic test_counters();
`ifdef CSR_COUNTERS_EN
    logic [9:0] ret_pat;
    ret_pat = 10'b01_0010_1001;
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      inst_retire_i = ret_pat[i];
      tick();
    end
    inst_retire_i = 1'b0;
    rd(12'hB00);
    checks++;
    if (csr_rdata_o !== 64'd10) begin
      errors++; $display("FAIL mcycle_count got %0d want 10", csr_rdata_o);
    end
    rd(12'hB02);
    checks++;
    if (csr_rdata_o !== 64'd4) begin
      errors++; $display("FAIL minstret_count got %0d want 4", csr_rdata_o);
    end
    wr(12'hB00, 2'b01, 64'hFFFF_FFFF_FFFF_FFFF);
    tick();
    rd(12'hB00);
    checks++;
    if (csr_rdata_o !== 64'hFFFF_FFFF_FFFF_FFFF) begin
      errors++; $display("FAIL mcycle_load got %h want all ones", csr_rdata_o);
    end
    tick();
    checks++;
    if (csr_rdata_o !== 64'd0) begin
      errors++; $display("FAIL mcycle_wrap got %h want 0", csr_rdata_o);
    end
`else
    rd(12'hB00);
    checks++;
    if (csr_illegal_o !== 1'b1 || csr_rdata_o !== 64'd0) begin
      errors++; $display("FAIL mcycle_absent ill %b rdata %h want ill 1 rdata 0", csr_illegal_o, csr_rdata_o);
    end
    rd(12'hB02);
    checks++;
    if (csr_illegal_o !== 1'b1) begin
      errors++; $display("FAIL minstret_absent ill %b want 1", csr_illegal_o);
    end
`endif
    idle();
  endtask

  task automatic test_reset_mid();
    trap_wen_i     = 1'b1;
    trap_mepc_i    = 64'h8000_1000;
    trap_mcause_i  = 64'd3;
    trap_mstatus_i = 64'h0;
    wr(12'h340, 2'b01, 64'h55);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle();
    rd(12'h340);
    checks++;
    if (csr_rdata_o !== 64'd0) begin
      errors++; $display("FAIL rst_mscratch got %h want 0", csr_rdata_o);
    end
    checks++;
    if (mepc_o !== 64'd0 || mstatus_o !== TB_MST) begin
      errors++; $display("FAIL rst_over_trap mepc %h mstatus %h want 0 %h", mepc_o, mstatus_o, TB_MST);
    end
  endtask

  initial begin
    rst = 1'b1;
    idle();
    test_reset();
    test_rw_rs_rc();
    test_masking();
    test_trap_conflict();
    test_illegal();
    test_counters();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
